// File: rtl/fm_ult_ser.sv
// Buffers wide ULT monitor words in a small FIFO and serialises each one into BEATS
// OUT_W-bit beats, LSB slice first. Optional macro FM_ULT_SER_DROP_CNT_EN: drop-and-count.
module fm_ult_ser #(
    parameter int IN_W       = 256,
    parameter int OUT_W      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_hs,
    input  logic             rst_hs,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             freeze,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    output logic             out_first,
    output logic             out_last,
    output logic [15:0]      drop_cnt
);
    localparam int BEATS  = IN_W / OUT_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [1:0]        rst_sync_q, rst_sync_d;
    logic [0:0]        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d, beat_inc;
    logic [IN_W-1:0]   shreg_q, shreg_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_first_q, out_first_d;
    logic              out_last_q, out_last_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [IN_W-1:0]   mem_q [FIFO_DEPTH];
    logic [IN_W-1:0]   head;
    logic              run, fifo_full, fifo_empty, push, pop, drop;

    // Internal enable only rises two edges after rst_hs is released.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign run        = rst_sync_q[1];
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign fifo_empty = (cnt_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign beat_inc   = beat_q + 1'b1;

`ifdef FM_ULT_SER_DROP_CNT_EN
    // A full FIFO discards the word even when a pop frees a slot on the same edge.
    assign in_ready = run;
    assign push     = in_valid & run & ~fifo_full;
    assign drop     = in_valid & run & fifo_full;
`else
    assign in_ready = run & ~fifo_full;
    assign push     = in_valid & in_ready;
    assign drop     = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        shreg_d     = shreg_q;
        out_data_d  = '0;
        out_valid_d = 1'b0;
        out_first_d = 1'b0;
        out_last_d  = 1'b0;
        pop         = 1'b0;
        if (run) begin
            if (state_q == ST_SHIFT && beat_q != LAST_BEAT) begin
                beat_d      = beat_inc;
                out_valid_d = 1'b1;
                out_data_d  = shreg_q[OUT_W-1:0];
                shreg_d     = shreg_q >> OUT_W;
                out_last_d  = (beat_inc == LAST_BEAT);
            end else if (!fifo_empty && !freeze) begin
                // Pop on the last beat too, so the next word follows without a bubble.
                pop         = 1'b1;
                state_d     = ST_SHIFT;
                beat_d      = '0;
                out_valid_d = 1'b1;
                out_data_d  = head[OUT_W-1:0];
                shreg_d     = head >> OUT_W;
                out_first_d = 1'b1;
                out_last_d  = (BEATS == 1);
            end else begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        cnt_d    = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_hs or negedge rst_hs) begin
        if (!rst_hs) begin
            rst_sync_q  <= '0;
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            shreg_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            rst_sync_q  <= rst_sync_d;
            state_q     <= state_d;
            beat_q      <= beat_d;
            shreg_q     <= shreg_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_hs) begin
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_first = out_first_q;
    assign out_last  = out_last_q;
    assign drop_cnt  = drop_cnt_q;
endmodule

// File: tb/tb_fm_ult_ser.sv
// Self-checking bench for fm_ult_ser: a queue-based stream model compared every cycle,
// plus directed scenarios with hand-computed beat counts and values.
module tb_fm_ult_ser;
    localparam int IN_W  = 256;
    localparam int OUT_W = 32;
    localparam int DEPTH = 4;
    localparam int BEATS = IN_W / OUT_W;
`ifdef FM_ULT_SER_DROP_CNT_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic             clk_hs = 1'b0;
    logic             rst_hs;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic             freeze;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_first;
    logic             out_last;
    logic [15:0]      drop_cnt;

    fm_ult_ser #(.IN_W(IN_W), .OUT_W(OUT_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk_hs(clk_hs), .rst_hs(rst_hs), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .freeze(freeze), .out_data(out_data), .out_valid(out_valid),
        .out_first(out_first), .out_last(out_last), .drop_cnt(drop_cnt)
    );

    always #5 clk_hs = ~clk_hs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    always @(posedge clk_hs) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stream model: queue of accepted words, current word and beat index (-1 = idle).
    logic [IN_W-1:0] mq[$];
    logic [IN_W-1:0] mcur = '0;
    int  mbeat = -1;
    int  msync = 0;
    int  mdrop = 0;
    bit  m_full, m_acc, m_drp;

    always @(posedge clk_hs or negedge rst_hs) begin
        if (!rst_hs) begin
            mq.delete();
            mbeat = -1;
            msync = 0;
            mdrop = 0;
        end else begin
            if (msync >= 2) begin
                m_full = (mq.size() == DEPTH);
                m_acc  = in_valid && !m_full;
                m_drp  = DROP && in_valid && m_full;
                if (mbeat >= 0 && mbeat < BEATS - 1) mbeat++;
                else if (mq.size() > 0 && !freeze) begin
                    mcur  = mq.pop_front();
                    mbeat = 0;
                end else mbeat = -1;
                if (m_acc) mq.push_back(in_data);
                if (m_drp && mdrop < 65535) mdrop++;
            end
            if (msync < 2) msync++;
        end
    end

    logic [OUT_W-1:0] g_data[$];
    bit               g_first[$];
    bit               g_last[$];
    int               g_cyc[$];
    logic [OUT_W-1:0] exp_data;
    bit               exp_valid, exp_ready;

    always @(negedge clk_hs) begin
        exp_valid = (mbeat >= 0);
        exp_data  = exp_valid ? mcur[mbeat*OUT_W +: OUT_W] : '0;
        exp_ready = (msync >= 2) && (DROP || mq.size() < DEPTH);
        chk("out_valid", 64'(out_valid), 64'(exp_valid));
        chk("out_data", 64'(out_data), 64'(exp_data));
        chk("out_first", 64'(out_first), 64'(exp_valid && mbeat == 0));
        chk("out_last", 64'(out_last), 64'(exp_valid && mbeat == BEATS - 1));
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        chk("drop_cnt", 64'(drop_cnt), 64'(mdrop));
        if (out_valid) begin
            g_data.push_back(out_data);
            g_first.push_back(out_first);
            g_last.push_back(out_last);
            g_cyc.push_back(cyc);
        end
    end

    function automatic logic [IN_W-1:0] mkword(input int base);
        logic [IN_W-1:0] w;
        for (int i = 0; i < BEATS; i++) w[i*OUT_W +: OUT_W] = OUT_W'(base + i);
        return w;
    endfunction

    task automatic clear_log();
        g_data.delete(); g_first.delete(); g_last.delete(); g_cyc.delete();
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_hs);
        #2;
    endtask

    task automatic push_word(input logic [IN_W-1:0] w);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk_hs);
            acc = in_ready;
            @(posedge clk_hs);
            #2;
        end
        if (acc) last_acc_cyc = cyc;
        else begin
            checks++; errors++;
            $display("FAIL push_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic wait_beats(input int n);
        bit hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(posedge clk_hs);
            hit = (g_data.size() >= n);
        end
        #2;
        if (!hit) begin
            checks++; errors++;
            $display("FAIL wait_beats actual=%0d required=%0d", g_data.size(), n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    int lasts;
    int exp_drop;

    initial begin
        rst_hs = 1'b0; in_valid = 1'b0; in_data = '0; freeze = 1'b0;
        step(3);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        rst_hs = 1'b1;
        step(1);
        chk("sync_edge1_ready", 64'(in_ready), 64'd0);
        step(1);
        chk("sync_edge2_ready", 64'(in_ready), 64'd1);

        // Single word, beat i = i+1
        clear_log();
        push_word(mkword(1));
        in_valid = 1'b0;
        step(15);
        chk("single_count", 64'(g_data.size()), 64'd8);
        for (int i = 0; i < g_data.size(); i++) begin
            chk("single_data", 64'(g_data[i]), 64'(i + 1));
            chk("single_first", 64'(g_first[i]), 64'(i == 0));
            chk("single_last", 64'(g_last[i]), 64'(i == 7));
        end
        if (g_cyc.size() > 0) chk("single_latency", 64'(g_cyc[0] - last_acc_cyc), 64'd1);

        // Three words back-to-back
        clear_log();
        push_word(mkword(16)); push_word(mkword(32)); push_word(mkword(48));
        in_valid = 1'b0;
        step(40);
        chk("b2b_count", 64'(g_data.size()), 64'd24);
        if (g_data.size() == 24) begin
            chk("b2b_contiguous", 64'(g_cyc[23] - g_cyc[0]), 64'd23);
            chk("b2b_last7", 64'(g_last[7]), 64'd1);
            chk("b2b_first8", 64'(g_first[8]), 64'd1);
            chk("b2b_data8", 64'(g_data[8]), 64'd32);
            chk("b2b_data23", 64'(g_data[23]), 64'd55);
        end

        // Six words on consecutive cycles: one overflows a 4-deep FIFO
        clear_log();
        for (int k = 0; k < 6; k++) push_word(mkword(64 + 16 * k));
        in_valid = 1'b0;
        step(80);
        exp_drop = DROP ? 1 : 0;
        chk("six_drop_cnt", 64'(drop_cnt), 64'(exp_drop));
        chk("six_count", 64'(g_data.size()), 64'(8 * (6 - exp_drop)));
        if (g_data.size() >= 33) chk("six_word4_beat0", 64'(g_data[32]), 64'd128);

        // Freeze mid-word with two words queued
        clear_log();
        push_word(mkword(300)); push_word(mkword(400)); push_word(mkword(500));
        in_valid = 1'b0;
        wait_beats(4);
        freeze = 1'b1;
        step(20);
        chk("freeze_count", 64'(g_data.size()), 64'd8);
        chk("freeze_idle", 64'(out_valid), 64'd0);
        if (g_last.size() >= 8) chk("freeze_last", 64'(g_last[7]), 64'd1);
        freeze = 1'b0;
        step(40);
        chk("unfreeze_count", 64'(g_data.size()), 64'd24);
        if (g_data.size() == 24) chk("unfreeze_data16", 64'(g_data[16]), 64'd500);

        // Reset mid-word
        clear_log();
        push_word(mkword(700));
        in_valid = 1'b0;
        wait_beats(5);
        rst_hs = 1'b0;
        #1;
        chk("rst_now_valid", 64'(out_valid), 64'd0);
        chk("rst_now_data", 64'(out_data), 64'd0);
        chk("rst_now_ready", 64'(in_ready), 64'd0);
        step(3);
        rst_hs = 1'b1;
        step(6);
        lasts = 0;
        foreach (g_last[i]) lasts += int'(g_last[i]);
        chk("rst_no_last", 64'(lasts), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        chk("rst_idle", 64'(out_valid), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);

        // Recovery after reset
        clear_log();
        push_word(mkword(900));
        in_valid = 1'b0;
        step(15);
        chk("recover_count", 64'(g_data.size()), 64'd8);
        if (g_data.size() == 8) chk("recover_data7", 64'(g_data[7]), 64'd907);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
